level_detector_scheduler: RTL and testbench
===========================================

// Module: level_detector_scheduler
// PURPOSE
//  Time-multiplexes one compression_level_detector-style level detector across
//  NUM_CHANNELS drum-pad audio channels. Latches per-channel dB samples and
//  grants the detector round-robin. Holds each channel's last detected level
//  and presents it as the detector's stored_db. Sits between the per-channel
//  linear->dB converters and the gain computer.
// PARAMETERS
//  NUM_CHANNELS    4   number of requesting channels (2..8)
//  DB_WIDTH        9   signed dB sample/level width
//  TIMEOUT_CYCLES  15  max cycles in WAIT for det_done before abort
// PORTS
//  clock            in   1               system clock
//  reset            in   1               synchronous, active-high
//  sample_valid     in   NUM_CHANNELS    per-channel 1-cycle sample strobe
//  sample_db        in   NUM_CHANNELS*9  packed signed dB; ch i = [9i+8:9i]
//  det_start        out  1               1-cycle start pulse to detector
//  det_input_db     out  9               signed sample for granted channel
//  det_stored_db    out  9               stored level for granted channel
//  det_done         in   1               detector done (level; high until next start)
//  det_output_level in   9               signed level from detector
//  level_out        out  9               last written-back level
//  level_valid      out  NUM_CHANNELS    1-cycle one-hot: level_out belongs to ch i
//  busy             out  1               high in any state except IDLE
//  overrun          out  NUM_CHANNELS    sticky: sample overwritten before service
//  timeout_err      out  1               sticky: detector failed to answer
// BEHAVIOUR
//  Reset: all outputs 0; pending, data_q, stored_level all 0; rr_ptr=0; state IDLE.
//  Capture: sample_valid[i] at edge t -> pending[i]=1, data_q[i]=sample_db[i].
//  FSM (registered outputs):
//   IDLE:  if any pending -> pick winner: first pending at or after rr_ptr,
//          wrapping modulo NUM_CHANNELS -> ISSUE. Else stay.
//   ISSUE (1 cyc): det_start=1; det_input_db=data_q[w]; det_stored_db=stored[w];
//          clear pending[w]; rr_ptr=(w+1) mod N; clear timer -> WAIT.
//   WAIT:  done_rise = det_done & ~done_q (done_q registered every cycle).
//          On done_rise -> WRITEBACK. Timer +1 per cycle; timer==TIMEOUT_CYCLES
//          with no done_rise -> timeout_err=1, no writeback, no level_valid -> IDLE.
//   WRITEBACK (1 cyc): stored[w]=det_output_level; level_out=det_output_level;
//          level_valid=1<<w -> IDLE.
//  det_input_db/det_stored_db hold their value outside ISSUE (detector samples them).
//  Latency: sample to level_valid = 1 (capture) + 1 (IDLE) + 1 (ISSUE) + detector
//   latency + 1 (edge detect) + 1 (WRITEBACK). Min 8 cycles with a 3-cycle detector.
//  Edge cases:
//   sample_valid[i] while pending[i]=1 and not cleared this cycle -> data
//    overwritten, overrun[i]=1 (sticky until reset).
//   sample_valid[w] in ISSUE cycle -> new sample wins: pending[w] stays 1, no overrun.
//   sample_valid[i] for granted ch during WAIT -> normal capture; serviced later.
//   det_done already high on entering WAIT -> not a completion (needs rising edge).
//   All channels pending -> strict rotation; each served once per N grants.
//   Signed dB is passed through unmodified; no saturation inside this block.
//   Reset mid-operation -> immediate return to reset state; a det_done arriving
//    afterwards is ignored (IDLE does not sample det_done except into done_q).
// STRUCTURE
//  Shared package: state encodings (IDLE/ISSUE/WAIT/WRITEBACK, 2 bits), DB_WIDTH.
//  Sub-module: rr_arbiter (pending vector + rr_ptr -> winner index, any_pending),
//   purely combinational; FSM, storage and timer remain in this module.
// TESTING
//  1 single: ch2 sample_valid, db=-20, stub detector returns -18 after 3 cyc ->
//    det_input_db=-20, det_stored_db=0; level_valid=4'b0100, level_out=-18;
//    stored[2]=-18.
//  2 round-robin: all 4 strobed same cycle -> grants 0,1,2,3 in order; then ch0,ch3
//    pending with rr_ptr=0 -> 0 then 3.
//  3 stored feedback: ch1 served twice (levels 5 then 7) -> second det_stored_db=5.
//  4 overrun: ch0 strobed twice (10, 12) while busy on ch3 -> overrun=4'b0001;
//    ch0 serviced once with det_input_db=12.
//  5 timeout: detector never raises done -> timeout_err=1 at WAIT cycle 15;
//    no level_valid; next pending channel still granted.
//  6 reset mid-WAIT, then detector done -> no level_valid; all outputs 0; busy=0.

Source files
------------

// File: rtl/level_detector_scheduler_pkg.sv
// rtl/level_detector_scheduler_pkg.sv - shared state encoding and widths for the level detector scheduler
package level_detector_scheduler_pkg;

  localparam int DEFAULT_DB_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT      = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

endpackage

// File: rtl/level_detector_scheduler_rr_arbiter.sv
// rtl/level_detector_scheduler_rr_arbiter.sv - combinational round-robin pick: first pending at or after rr_ptr
module level_detector_scheduler_rr_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int PTR_W        = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] pending_i,
  input  logic [PTR_W-1:0]        rr_ptr_i,
  output logic [PTR_W-1:0]        winner_o,
  output logic                    any_pending_o
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest pending channel overwrites last.
  always_comb begin
    winner_o      = '0;
    idx           = '0;
    any_pending_o = |pending_i;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_CHANNELS);
      if (pending_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/level_detector_scheduler.sv
// rtl/level_detector_scheduler.sv - shares one level detector across channels, round-robin, with per-channel level storage
module level_detector_scheduler
  import level_detector_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int DB_WIDTH       = DEFAULT_DB_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CHANNELS-1:0]          sample_valid,
  input  logic [NUM_CHANNELS*DB_WIDTH-1:0] sample_db,
  output logic                             det_start,
  output logic signed [DB_WIDTH-1:0]       det_input_db,
  output logic signed [DB_WIDTH-1:0]       det_stored_db,
  input  logic                             det_done,
  input  logic signed [DB_WIDTH-1:0]       det_output_level,
  output logic signed [DB_WIDTH-1:0]       level_out,
  output logic [NUM_CHANNELS-1:0]          level_valid,
  output logic                             busy,
  output logic [NUM_CHANNELS-1:0]          overrun,
  output logic                             timeout_err
);

  localparam int PTR_W = $clog2(NUM_CHANNELS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e state_q, state_d;

  logic [NUM_CHANNELS-1:0]    pending_q, pending_d;
  logic signed [DB_WIDTH-1:0] data_q   [NUM_CHANNELS];
  logic signed [DB_WIDTH-1:0] data_d   [NUM_CHANNELS];
  logic signed [DB_WIDTH-1:0] stored_q [NUM_CHANNELS];
  logic signed [DB_WIDTH-1:0] stored_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    overrun_q, overrun_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]           win_q, win_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       done_q;
  logic                       start_q, start_d;
  logic signed [DB_WIDTH-1:0] in_db_q, in_db_d;
  logic signed [DB_WIDTH-1:0] st_db_q, st_db_d;
  logic signed [DB_WIDTH-1:0] level_q, level_d;
  logic [NUM_CHANNELS-1:0]    lvalid_q, lvalid_d;
  logic                       timeout_q, timeout_d;

  logic [NUM_CHANNELS-1:0]    clear_vec;
  logic [PTR_W-1:0]           arb_winner;
  logic                       arb_any;
  logic                       done_rise;

  level_detector_scheduler_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PTR_W        (PTR_W)
  ) u_arb (
    .pending_i     (pending_q),
    .rr_ptr_i      (rr_ptr_q),
    .winner_o      (arb_winner),
    .any_pending_o (arb_any)
  );

  // Only a fresh rising edge completes; a done left high from the previous job is ignored.
  assign done_rise = det_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
    stored_d  = stored_q;
    overrun_d = overrun_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    in_db_d   = in_db_q;
    st_db_d   = st_db_q;
    level_d   = level_q;
    lvalid_d  = '0;
    timeout_d = timeout_q;
    clear_vec = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d               = ST_ISSUE;
          win_d                 = arb_winner;
          start_d               = 1'b1;
          in_db_d               = data_q[arb_winner];
          st_db_d               = stored_q[arb_winner];
          clear_vec[arb_winner] = 1'b1;
          rr_ptr_d              = (arb_winner == PTR_W'(NUM_CHANNELS - 1)) ? '0
                                                                          : arb_winner + PTR_W'(1);
          timer_d               = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_d         = ST_WRITEBACK;
          stored_d[win_q] = det_output_level;
          level_d         = det_output_level;
          lvalid_d[win_q] = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A strobe on the channel being granted this cycle re-arms it without flagging overrun.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (clear_vec[i]) begin
        pending_d[i] = 1'b0;
      end
      if (sample_valid[i]) begin
        if (pending_q[i] && !clear_vec[i]) begin
          overrun_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
        data_d[i]    = sample_db[i*DB_WIDTH +: DB_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      in_db_q   <= '0;
      st_db_q   <= '0;
      level_q   <= '0;
      lvalid_q  <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        data_q[i]   <= '0;
        stored_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      done_q    <= det_done;
      start_q   <= start_d;
      in_db_q   <= in_db_d;
      st_db_q   <= st_db_d;
      level_q   <= level_d;
      lvalid_q  <= lvalid_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      stored_q  <= stored_d;
    end
  end

  assign det_start     = start_q;
  assign det_input_db  = in_db_q;
  assign det_stored_db = st_db_q;
  assign level_out     = level_q;
  assign level_valid   = lvalid_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_level_detector_scheduler.sv
// tb/tb_level_detector_scheduler.sv - scoreboard bench with a stub detector for the level detector scheduler
module tb_level_detector_scheduler;

  localparam int N = 4;
  localparam int W = 9;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        sample_valid;
  logic [N*W-1:0]      sample_db;
  logic                det_start;
  logic signed [W-1:0] det_input_db;
  logic signed [W-1:0] det_stored_db;
  logic                det_done;
  logic signed [W-1:0] det_output_level;
  logic signed [W-1:0] level_out;
  logic [N-1:0]        level_valid;
  logic                busy;
  logic [N-1:0]        overrun;
  logic                timeout_err;

  level_detector_scheduler #(
    .NUM_CHANNELS   (N),
    .DB_WIDTH       (W),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .sample_valid     (sample_valid),
    .sample_db        (sample_db),
    .det_start        (det_start),
    .det_input_db     (det_input_db),
    .det_stored_db    (det_stored_db),
    .det_done         (det_done),
    .det_output_level (det_output_level),
    .level_out        (level_out),
    .level_valid      (level_valid),
    .busy             (busy),
    .overrun          (overrun),
    .timeout_err      (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic signed [W-1:0] in_db; logic signed [W-1:0] st_db; } grant_t;
  typedef struct { logic [N-1:0] mask; logic signed [W-1:0] lvl; } level_t;
  typedef struct { bit hang; logic signed [W-1:0] lvl; } resp_t;

  grant_t exp_grant[$];
  level_t exp_level[$];
  resp_t  resp_q[$];
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Stub detector: answers 3 cycles after det_start unless told to hang; done stays high until next start.
  int    stub_cnt = 0;
  resp_t stub_r;
  always @(negedge clock) begin
    if (det_start === 1'b1) begin
      det_done = 1'b0;
      stub_cnt = 3;
      if (resp_q.size() > 0) stub_r = resp_q.pop_front();
      else stub_r = '{hang: 1'b1, lvl: '0};
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && !stub_r.hang) begin
        det_done         = 1'b1;
        det_output_level = stub_r.lvl;
      end
    end
  end

  grant_t g_mon;
  level_t l_mon;
  always @(negedge clock) begin
    if (det_start === 1'b1) begin
      if (exp_grant.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_start: in=%0d stored=%0d want no start", det_input_db, det_stored_db);
      end else begin
        g_mon = exp_grant.pop_front();
        check("grant_input_db", det_input_db, g_mon.in_db);
        check("grant_stored_db", det_stored_db, g_mon.st_db);
      end
    end
    if (level_valid !== '0) begin
      if (exp_level.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_level_valid: mask=%b level=%0d want none", level_valid, level_out);
      end else begin
        l_mon = exp_level.pop_front();
        check("level_valid_mask", 32'(level_valid), 32'(l_mon.mask));
        check("level_out", level_out, l_mon.lvl);
      end
    end
  end

  task automatic expect_job(input int in_db, input int st_db, input bit hang, input int lvl, input int ch);
    exp_grant.push_back('{in_db: W'(in_db), st_db: W'(st_db)});
    resp_q.push_back('{hang: hang, lvl: W'(lvl)});
    if (!hang) exp_level.push_back('{mask: N'(1 << ch), lvl: W'(lvl)});
  endtask

  task automatic strobe(input logic [N-1:0] mask, input int v0, input int v1, input int v2, input int v3);
    sample_valid = mask;
    sample_db    = {W'(v3), W'(v2), W'(v1), W'(v0)};
    @(negedge clock);
    sample_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_level.size() != 0 || busy) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL %s_wait: queues grant=%0d level=%0d busy=%0b after %0d cycles, want drained", name,
               exp_grant.size(), exp_level.size(), busy, n);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (det_start !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL %s_start: det_start=%0b after %0d cycles, want 1", name, det_start, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_det_start"}, 32'(det_start), 0);
    check({name, "_det_input_db"}, det_input_db, 0);
    check({name, "_det_stored_db"}, det_stored_db, 0);
    check({name, "_level_out"}, level_out, 0);
    check({name, "_level_valid"}, 32'(level_valid), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_overrun"}, 32'(overrun), 0);
    check({name, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    reset            = 1'b1;
    sample_valid     = '0;
    sample_db        = '0;
    det_done         = 1'b0;
    det_output_level = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // single channel, then same channel again to see the stored level fed back
    expect_job(-20, 0, 1'b0, -18, 2);
    strobe(4'b0100, 0, 0, -20, 0);
    wait_quiet("single");
    expect_job(-25, -18, 1'b0, -19, 2);
    strobe(4'b0100, 0, 0, -25, 0);
    wait_quiet("single_again");
    do_reset();

    // round-robin across all channels, then 0 and 3 with the pointer back at 0
    for (int i = 0; i < N; i++) expect_job(11 + i, 0, 1'b0, 21 + i, i);
    strobe(4'b1111, 11, 12, 13, 14);
    wait_quiet("rr_all");
    expect_job(30, 21, 1'b0, 40, 0);
    expect_job(33, 24, 1'b0, 43, 3);
    strobe(4'b1001, 30, 0, 0, 33);
    wait_quiet("rr_pair");
    do_reset();

    // stored feedback on ch1
    expect_job(50, 0, 1'b0, 5, 1);
    strobe(4'b0010, 0, 50, 0, 0);
    wait_quiet("fb_first");
    expect_job(51, 5, 1'b0, 7, 1);
    strobe(4'b0010, 0, 51, 0, 0);
    wait_quiet("fb_second");
    check("fb_overrun", 32'(overrun), 0);

    // overrun: ch0 strobed twice while ch3 is in service
    expect_job(60, 0, 1'b0, 61, 3);
    strobe(4'b1000, 0, 0, 0, 60);
    repeat (3) @(negedge clock);
    check("ovr_busy", 32'(busy), 1);
    expect_job(12, 0, 1'b0, 13, 0);
    strobe(4'b0001, 10, 0, 0, 0);
    strobe(4'b0001, 12, 0, 0, 0);
    wait_quiet("overrun");
    check("overrun_flag", 32'(overrun), 32'(4'b0001));
    do_reset();

    // timeout on ch1, ch2 still serviced afterwards
    expect_job(70, 0, 1'b1, 0, 1);
    expect_job(80, 0, 1'b0, 81, 2);
    strobe(4'b0110, 0, 70, 80, 0);
    wait_start("timeout");
    repeat (15) @(negedge clock);
    check("timeout_not_yet", 32'(timeout_err), 0);
    @(negedge clock);
    check("timeout_set", 32'(timeout_err), 1);
    wait_quiet("timeout");
    check("timeout_sticky", 32'(timeout_err), 1);
    do_reset();

    // reset during WAIT, detector answers afterwards
    exp_grant.push_back('{in_db: W'(90), st_db: W'(0)});
    resp_q.push_back('{hang: 1'b0, lvl: W'(91)});
    strobe(4'b0001, 90, 0, 0, 0);
    wait_start("midreset");
    @(negedge clock);
    check("midreset_busy_before", 32'(busy), 1);
    do_reset();
    check_all_zero("midreset");
    repeat (5) @(negedge clock);
    check_all_zero("after_done");

    check("end_grant_queue", exp_grant.size(), 0);
    check("end_level_queue", exp_level.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
